// File: rtl/imem_access_arbiter_if.sv
// Bundle of the fetch port, loader port and memory-side signals of the imem arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters'/memory's view.
// No state lives here; timing and backpressure are defined by the arbiter.
interface imem_access_arbiter_if #(
  parameter int AW = 8
);
  // fetch port (read-only)
  logic          f_req;
  logic [31:0]   f_addr;
  logic          f_gnt;
  logic          f_valid;
  logic [31:0]   f_rdata;
  logic          f_err;
  // loader/debug port (read/write)
  logic          l_req;
  logic          l_we;
  logic [31:0]   l_addr;
  logic [31:0]   l_wdata;
  logic          l_gnt;
  logic          l_valid;
  logic [31:0]   l_rdata;
  logic          l_err;
  // memory array side
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  // status
  logic          busy;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_valid, f_rdata, f_err,
    output l_gnt, l_valid, l_rdata, l_err,
    output mem_addr, mem_we, mem_wdata, busy
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_valid, f_rdata, f_err,
    input  l_gnt, l_valid, l_rdata, l_err,
    input  mem_addr, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/imem_access_arbiter.sv
// Round-robin arbiter sharing one single-port instruction memory between fetch (F) and loader (L).
// Latency: grant at cycle T, valid pulse at T+WAIT_CYCLES+1; one access per WAIT_CYCLES+1 cycles.
// Backpressure: requesters hold req until the combinational gnt, which is only given in IDLE.
// Optional macro IMEM_RANGE_CHK_EN: addresses >= DEPTH complete with err=1, rdata=0 and no
// memory write; without it addresses wrap to addr[AW-1:0] and err is always 0.
module imem_access_arbiter #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  imem_access_arbiter_if.slave bus
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_l_q, last_l_d;   // 1: loader was granted last, so fetch wins a tie
  logic          own_l_q, own_l_d;     // owner of the access in flight
  logic          we_q, we_d;
  logic          oor_q, oor_d;         // latched out-of-range flag
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          f_valid_q, f_valid_d;
  logic          l_valid_q, l_valid_d;
  logic [31:0]   f_rdata_q, f_rdata_d;
  logic [31:0]   l_rdata_q, l_rdata_d;
  logic          f_err_q, f_err_d;
  logic          l_err_q, l_err_d;

  logic          gnt_f;
  logic          gnt_l;
  logic [31:0]   sel_addr;
  logic          sel_oor;
  logic          last_cyc;
  logic [31:0]   rd_val;

  // Arbitration, range check and memory-side strobes
  always_comb begin
    gnt_f    = (state_q == S_IDLE) && bus.f_req && (!bus.l_req || last_l_q);
    gnt_l    = (state_q == S_IDLE) && bus.l_req && !gnt_f;
    sel_addr = gnt_l ? bus.l_addr : bus.f_addr;
`ifdef IMEM_RANGE_CHK_EN
    sel_oor  = (sel_addr >= 32'(DEPTH));
`else
    sel_oor  = 1'b0;
`endif
    last_cyc = (state_q == S_ACCESS) && (cnt_q == '0);
    rd_val   = oor_q ? 32'd0 : bus.mem_rdata;
  end

  assign bus.f_gnt     = gnt_f;
  assign bus.l_gnt     = gnt_l;
  assign bus.busy      = (state_q == S_ACCESS);
  assign bus.mem_addr  = (state_q == S_ACCESS) ? addr_q : '0;
  assign bus.mem_we    = last_cyc && we_q && !oor_q;
  assign bus.mem_wdata = bus.mem_we ? wdata_q : 32'd0;
  assign bus.f_valid   = f_valid_q;
  assign bus.f_rdata   = f_rdata_q;
  assign bus.f_err     = f_err_q;
  assign bus.l_valid   = l_valid_q;
  assign bus.l_rdata   = l_rdata_q;
  assign bus.l_err     = l_err_q;

  // Next-state: grant/latch in IDLE, count down in ACCESS, complete on the last cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_l_d  = last_l_q;
    own_l_d   = own_l_q;
    we_d      = we_q;
    oor_d     = oor_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    f_valid_d = 1'b0;
    l_valid_d = 1'b0;
    f_rdata_d = f_rdata_q;
    l_rdata_d = l_rdata_q;
    f_err_d   = f_err_q;
    l_err_d   = l_err_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_f || gnt_l) begin
          state_d  = S_ACCESS;
          cnt_d    = CW'(WAIT_CYCLES - 1);
          last_l_d = gnt_l;
          own_l_d  = gnt_l;
          we_d     = gnt_l && bus.l_we;
          oor_d    = sel_oor;
          addr_d   = sel_addr[AW-1:0];
          wdata_d  = gnt_l ? bus.l_wdata : 32'd0;
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_IDLE;
          if (own_l_q) begin
            l_valid_d = 1'b1;
            l_rdata_d = we_q ? 32'd0 : rd_val;
            l_err_d   = oor_q;
          end else begin
            f_valid_d = 1'b1;
            f_rdata_d = rd_val;
            f_err_d   = oor_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; an asynchronous reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_l_q  <= 1'b1;
      own_l_q   <= 1'b0;
      we_q      <= 1'b0;
      oor_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      f_valid_q <= 1'b0;
      l_valid_q <= 1'b0;
      f_rdata_q <= 32'd0;
      l_rdata_q <= 32'd0;
      f_err_q   <= 1'b0;
      l_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_l_q  <= last_l_d;
      own_l_q   <= own_l_d;
      we_q      <= we_d;
      oor_q     <= oor_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      f_valid_q <= f_valid_d;
      l_valid_q <= l_valid_d;
      f_rdata_q <= f_rdata_d;
      l_rdata_q <= l_rdata_d;
      f_err_q   <= f_err_d;
      l_err_q   <= l_err_d;
    end
  end

endmodule
